// File: rtl/mux_3_1.sv
// Three-input selector with a registered copy of the output, plus an
// illegal-select flag and a saturating debug counter of illegal-select edges.
module mux_3_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] w_out;
  logic             w_selErr;
  logic [WIDTH-1:0] r_outQ;
  logic [CNT_W-1:0] r_errCnt;

  // Illegal or unknown select codes fall into the default arm and drive zeros.
  always_comb begin
    w_out = '0;
    case (sel)
      2'b00:   w_out = a;
      2'b01:   w_out = b;
      2'b10:   w_out = c;
      default: w_out = '0;
    endcase
  end

  assign w_selErr = (sel == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outQ <= '0;
    end else begin
      r_outQ <= w_out;
    end
  end

  // Counter stops at all-ones so a long illegal burst never wraps back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCnt <= '0;
    end else if (w_selErr && (r_errCnt != {CNT_W{1'b1}})) begin
      r_errCnt <= r_errCnt + 1'b1;
    end
  end

  assign out     = w_out;
  assign sel_err = w_selErr;
  assign out_q   = r_outQ;
  assign err_cnt = r_errCnt;

endmodule

// File: tb/tb_mux_3_1.sv
// Directed bench for mux_3_1: a WIDTH=1 instance, a WIDTH=1/CNT_W=2 instance
// sharing its inputs, and a WIDTH=8 instance with its own inputs.
module tb_mux_3_1;

  logic       clk;
  logic       rst;
  logic       a, b, c;
  logic [1:0] sel;
  logic [7:0] a8, b8, c8;
  logic [1:0] sel8;

  logic       out1, outQ1, selErr1;
  logic [7:0] errCnt1;
  logic       outS, outQS, selErrS;
  logic [1:0] errCntS;
  logic [7:0] out8, outQ8;
  logic       selErr8;
  logic [7:0] errCnt8;

  int total;
  int bad;

  mux_3_1 #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .sel(sel),
    .out(out1), .out_q(outQ1), .sel_err(selErr1), .err_cnt(errCnt1)
  );

  mux_3_1 #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .sel(sel),
    .out(outS), .out_q(outQS), .sel_err(selErrS), .err_cnt(errCntS)
  );

  mux_3_1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sel(sel8),
    .out(out8), .out_q(outQ8), .sel_err(selErr8), .err_cnt(errCnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ia, input logic ib, input logic ic, input logic [1:0] isel);
    a = ia;
    b = ib;
    c = ic;
    sel = isel;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    a = 0; b = 0; c = 0; sel = 2'b00;
    a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; sel8 = 2'b00;
    #2;
    checkOutput("rst_outq", 16'(outQ1), 16'h0);
    checkOutput("rst_errcnt", 16'(errCnt1), 16'h0);

    // Combinational vectors while reset holds the counters at zero.
    applyStimulus(0, 0, 0, 2'b01); checkOutput("comb_b0", 16'(out1), 16'h0);
    applyStimulus(1, 1, 0, 2'b01); checkOutput("comb_b1", 16'(out1), 16'h1);
    applyStimulus(0, 1, 0, 2'b00); checkOutput("comb_a0", 16'(out1), 16'h0);
    applyStimulus(1, 1, 1, 2'b00); checkOutput("comb_a1", 16'(out1), 16'h1);
    applyStimulus(0, 0, 1, 2'b10); checkOutput("comb_c1a", 16'(out1), 16'h1);
    applyStimulus(0, 1, 1, 2'b10); checkOutput("comb_c1b", 16'(out1), 16'h1);
    checkOutput("selerr_legal", 16'(selErr1), 16'h0);
    applyStimulus(0, 0, 1, 2'b11);
    checkOutput("ill1_out", 16'(out1), 16'h0);
    checkOutput("ill1_err", 16'(selErr1), 16'h1);
    applyStimulus(1, 0, 0, 2'b11);
    checkOutput("ill2_out", 16'(out1), 16'h0);
    checkOutput("ill2_err", 16'(selErr1), 16'h1);

    a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hF0;
    sel8 = 2'b00; #1; checkOutput("w8_sel00", 16'(out8), 16'h00A5);
    sel8 = 2'b01; #1; checkOutput("w8_sel01", 16'(out8), 16'h003C);
    sel8 = 2'b10; #1; checkOutput("w8_sel10", 16'(out8), 16'h00F0);
    sel8 = 2'b11; #1; checkOutput("w8_sel11", 16'(out8), 16'h0000);
    checkOutput("w8_selerr", 16'(selErr8), 16'h1);
    sel8 = 2'b00;

    applyStimulus(1, 0, 0, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Registered path: one-cycle latency, mid-cycle select change only affects out.
    tick();
    checkOutput("reg_outq1", 16'(outQ1), 16'h1);
    #2;
    applyStimulus(1, 0, 0, 2'b01);
    checkOutput("reg_out_now", 16'(out1), 16'h0);
    checkOutput("reg_outq_hold", 16'(outQ1), 16'h1);
    tick();
    checkOutput("reg_outq0", 16'(outQ1), 16'h0);
    checkOutput("w8_outq", 16'(outQ8), 16'h00A5);

    // Five illegal edges.
    applyStimulus(1, 0, 0, 2'b11);
    repeat (5) tick();
    checkOutput("cnt5", 16'(errCnt1), 16'h5);
    checkOutput("cnt_sat_early", 16'(errCntS), 16'h3);
    applyStimulus(1, 0, 0, 2'b00);
    tick();
    checkOutput("cnt_hold", 16'(errCnt1), 16'h5);
    checkOutput("outq_before_rst", 16'(outQ1), 16'h1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_outq", 16'(outQ1), 16'h0);
    checkOutput("arst_errcnt", 16'(errCnt1), 16'h0);
    checkOutput("arst_out_track1", 16'(out1), 16'h1);
    applyStimulus(0, 0, 0, 2'b00);
    checkOutput("arst_out_track0", 16'(out1), 16'h0);
    tick();
    checkOutput("arst_hold_cnt", 16'(errCnt1), 16'h0);
    rst = 1'b0;

    // Saturation on the 2-bit counter.
    applyStimulus(0, 0, 0, 2'b11);
    repeat (6) tick();
    checkOutput("sat_cnt2", 16'(errCntS), 16'h3);
    checkOutput("sat_cnt8", 16'(errCnt1), 16'h6);
    applyStimulus(0, 0, 0, 2'b00);
    repeat (2) tick();
    checkOutput("sat_hold2", 16'(errCntS), 16'h3);
    checkOutput("sat_hold8", 16'(errCnt1), 16'h6);
    checkOutput("w8_cnt_idle", 16'(errCnt8), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
